// File: rtl/cluster_centroid_n.sv
// cluster_centroid_n: multi-cluster colour tracker.
// Each streamed pixel goes to the nearest reference colour (Manhattan
// distance, within DIST_THRESH) or to background. Per-cluster count and x/y
// sums build up over the frame. At frame end a shared restoring divider
// turns the sums into floor-average centroids while the next frame is
// already being accumulated.
// Optional bounding-box outputs: define CLUSTER_BBOX_EN.
module cluster_centroid_n #(
  parameter int IMG_WIDTH    = 640,
  parameter int IMG_HEIGHT   = 480,
  parameter int NUM_CLUSTERS = 3,
  parameter int COLOR_W      = 12,
  parameter int DIST_THRESH  = 64,
  parameter int MIN_COUNT    = 4,
  localparam int XW = $clog2(IMG_WIDTH),
  localparam int YW = $clog2(IMG_HEIGHT),
  localparam int IW = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [COLOR_W-1:0]    pixel_r,
  input  logic signed [COLOR_W-1:0]    pixel_g,
  input  logic signed [COLOR_W-1:0]    pixel_b,
  input  logic                         pixel_valid,
  input  logic [XW-1:0]                x,
  input  logic [YW-1:0]                y,
  input  logic                         ref_wr_en,
  input  logic [IW-1:0]                ref_wr_idx,
  input  logic signed [COLOR_W-1:0]    ref_wr_r,
  input  logic signed [COLOR_W-1:0]    ref_wr_g,
  input  logic signed [COLOR_W-1:0]    ref_wr_b,
  output logic [NUM_CLUSTERS*XW-1:0]   centroid_x,
  output logic [NUM_CLUSTERS*YW-1:0]   centroid_y,
  output logic [NUM_CLUSTERS-1:0]      found,
  output logic                         frame_done,
  output logic                         busy,
`ifdef CLUSTER_BBOX_EN
  output logic [NUM_CLUSTERS*XW-1:0]   bbox_xmin,
  output logic [NUM_CLUSTERS*XW-1:0]   bbox_xmax,
  output logic [NUM_CLUSTERS*YW-1:0]   bbox_ymin,
  output logic [NUM_CLUSTERS*YW-1:0]   bbox_ymax,
`endif
  output logic                         overrun
);

  localparam int DW       = COLOR_W + 3;
  localparam int CW       = $clog2(IMG_WIDTH * IMG_HEIGHT + 1);
  localparam int SUM_W    = $clog2(IMG_WIDTH * IMG_WIDTH * IMG_HEIGHT);
  localparam int QW       = (XW > YW) ? XW : YW;
  localparam int SW       = $clog2(2 * NUM_CLUSTERS);
  localparam int BW       = $clog2(SUM_W);
  localparam logic [SW-1:0] LAST_SEL = SW'(2 * NUM_CLUSTERS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(SUM_W - 1);
  localparam logic signed [DW-1:0] THRESH = DW'(DIST_THRESH);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_LOAD} state_t;

  function automatic logic signed [DW-1:0] abs_diff(
    input logic signed [COLOR_W-1:0] a,
    input logic signed [COLOR_W-1:0] b
  );
    logic signed [DW-1:0] t;
    t = {{3{a[COLOR_W-1]}}, a} - {{3{b[COLOR_W-1]}}, b};
    return t[DW-1] ? -t : t;
  endfunction

  // Reference colours.
  logic signed [COLOR_W-1:0] r_ref_r [NUM_CLUSTERS];
  logic signed [COLOR_W-1:0] r_ref_g [NUM_CLUSTERS];
  logic signed [COLOR_W-1:0] r_ref_b [NUM_CLUSTERS];

  // Stage 1: registered pixel position and per-cluster distances.
  logic                 r_s1_valid, r_s1_eof;
  logic [XW-1:0]        r_s1_x;
  logic [YW-1:0]        r_s1_y;
  logic signed [DW-1:0] r_s1_d [NUM_CLUSTERS];

  // Stage 2: winning cluster.
  logic                 w_match;
  logic [IW-1:0]        w_win;
  logic signed [DW-1:0] w_best;
  logic                 r_s2_hit, r_s2_eof;
  logic [IW-1:0]        r_s2_idx;
  logic [XW-1:0]        r_s2_x;
  logic [YW-1:0]        r_s2_y;

  // Stage 3: live accumulators and their values including the stage-2 pixel.
  logic [CW-1:0]    r_cnt [NUM_CLUSTERS];
  logic [SUM_W-1:0] r_sx  [NUM_CLUSTERS];
  logic [SUM_W-1:0] r_sy  [NUM_CLUSTERS];
  logic [NUM_CLUSTERS-1:0] w_hit;
  logic [CW-1:0]    w_fin_cnt [NUM_CLUSTERS];
  logic [SUM_W-1:0] w_fin_sx  [NUM_CLUSTERS];
  logic [SUM_W-1:0] w_fin_sy  [NUM_CLUSTERS];

  // Frame snapshot consumed by the divider.
  logic [CW-1:0]    r_snap_cnt [NUM_CLUSTERS];
  logic [SUM_W-1:0] r_snap_sx  [NUM_CLUSTERS];
  logic [SUM_W-1:0] r_snap_sy  [NUM_CLUSTERS];

  // Divider control and datapath.
  state_t           r_state;
  logic [SW-1:0]    r_sel;
  logic [BW-1:0]    r_bit;
  logic [SUM_W-1:0] r_dvd;
  logic [CW-1:0]    r_rem;
  logic [QW-1:0]    r_quo;
  logic [XW-1:0]    r_qx [NUM_CLUSTERS];
  logic [YW-1:0]    r_qy [NUM_CLUSTERS];
  logic [IW-1:0]    w_cl;
  logic             w_last_bit, w_snap_go, w_ge;
  logic [SUM_W-1:0] w_dvd_in;
  logic [CW-1:0]    w_rem_in, w_divisor, w_rem_nx;
  logic [CW:0]      w_rem_sh;
  logic [QW-1:0]    w_quo_in, w_quo_nx;

  // Published results.
  logic [NUM_CLUSTERS*XW-1:0] r_centroid_x;
  logic [NUM_CLUSTERS*YW-1:0] r_centroid_y;
  logic [NUM_CLUSTERS-1:0]    r_found;
  logic                       r_frame_done, r_busy, r_overrun;

`ifdef CLUSTER_BBOX_EN
  logic [XW-1:0] r_xmin [NUM_CLUSTERS];
  logic [XW-1:0] r_xmax [NUM_CLUSTERS];
  logic [YW-1:0] r_ymin [NUM_CLUSTERS];
  logic [YW-1:0] r_ymax [NUM_CLUSTERS];
  logic [XW-1:0] w_fin_xmin [NUM_CLUSTERS];
  logic [XW-1:0] w_fin_xmax [NUM_CLUSTERS];
  logic [YW-1:0] w_fin_ymin [NUM_CLUSTERS];
  logic [YW-1:0] w_fin_ymax [NUM_CLUSTERS];
  logic [XW-1:0] r_snap_xmin [NUM_CLUSTERS];
  logic [XW-1:0] r_snap_xmax [NUM_CLUSTERS];
  logic [YW-1:0] r_snap_ymin [NUM_CLUSTERS];
  logic [YW-1:0] r_snap_ymax [NUM_CLUSTERS];
  logic [NUM_CLUSTERS*XW-1:0] r_bbox_xmin, r_bbox_xmax;
  logic [NUM_CLUSTERS*YW-1:0] r_bbox_ymin, r_bbox_ymax;
`endif

  // Reference colour table: reset defaults spread across colour space, runtime writable.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CLUSTERS; k++) begin
        r_ref_r[k] <= COLOR_W'(50  + 450 * k);
        r_ref_g[k] <= COLOR_W'(100 + 450 * k);
        r_ref_b[k] <= COLOR_W'(150 + 450 * k);
      end
    end else begin
      for (int k = 0; k < NUM_CLUSTERS; k++) begin
        if (ref_wr_en && ref_wr_idx == IW'(k)) begin
          r_ref_r[k] <= ref_wr_r;
          r_ref_g[k] <= ref_wr_g;
          r_ref_b[k] <= ref_wr_b;
        end
      end
    end
  end

  // Pipeline qualifiers: valid and frame-end flags travel with each pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_eof   <= 1'b0;
      r_s2_hit   <= 1'b0;
      r_s2_eof   <= 1'b0;
    end else begin
      r_s1_valid <= pixel_valid;
      r_s1_eof   <= pixel_valid && x == XW'(IMG_WIDTH - 1) && y == YW'(IMG_HEIGHT - 1);
      r_s2_hit   <= r_s1_valid && w_match;
      r_s2_eof   <= r_s1_eof;
    end
  end

  // Pipeline payload: distances against the table as it stood when the pixel arrived.
  // NOTE: payload and snapshot registers carry no reset; they are only read when qualified.
  always_ff @(posedge clk) begin
    r_s1_x   <= x;
    r_s1_y   <= y;
    for (int k = 0; k < NUM_CLUSTERS; k++)
      r_s1_d[k] <= abs_diff(pixel_r, r_ref_r[k]) + abs_diff(pixel_g, r_ref_g[k])
                 + abs_diff(pixel_b, r_ref_b[k]);
    r_s2_idx <= w_win;
    r_s2_x   <= r_s1_x;
    r_s2_y   <= r_s1_y;
  end

  // Nearest in-threshold cluster; strict < keeps the lowest index on ties.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_match = 1'b0;
    w_win   = '0;
    w_best  = '0;
    for (int k = 0; k < NUM_CLUSTERS; k++) begin
      if (r_s1_d[k] <= THRESH && (!w_match || r_s1_d[k] < w_best)) begin
        w_match = 1'b1;
        w_win   = IW'(k);
        w_best  = r_s1_d[k];
      end
    end
  end

  // Accumulator values after adding the pixel currently in stage 3.
  always_comb begin
    for (int k = 0; k < NUM_CLUSTERS; k++) begin
      w_hit[k]     = r_s2_hit && r_s2_idx == IW'(k);
      w_fin_cnt[k] = r_cnt[k] + (w_hit[k] ? CW'(1) : CW'(0));
      w_fin_sx[k]  = r_sx[k] + (w_hit[k] ? SUM_W'(r_s2_x) : SUM_W'(0));
      w_fin_sy[k]  = r_sy[k] + (w_hit[k] ? SUM_W'(r_s2_y) : SUM_W'(0));
`ifdef CLUSTER_BBOX_EN
      w_fin_xmin[k] = (w_hit[k] && r_s2_x < r_xmin[k]) ? r_s2_x : r_xmin[k];
      w_fin_xmax[k] = (w_hit[k] && r_s2_x > r_xmax[k]) ? r_s2_x : r_xmax[k];
      w_fin_ymin[k] = (w_hit[k] && r_s2_y < r_ymin[k]) ? r_s2_y : r_ymin[k];
      w_fin_ymax[k] = (w_hit[k] && r_s2_y > r_ymax[k]) ? r_s2_y : r_ymax[k];
`endif
    end
  end

  // Live accumulators: restart at every frame end whether or not the divider takes the snapshot.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CLUSTERS; k++) begin
      if (rst || r_s2_eof) begin
        r_cnt[k] <= '0;
        r_sx[k]  <= '0;
        r_sy[k]  <= '0;
`ifdef CLUSTER_BBOX_EN
        r_xmin[k] <= '1;
        r_xmax[k] <= '0;
        r_ymin[k] <= '1;
        r_ymax[k] <= '0;
`endif
      end else begin
        r_cnt[k] <= w_fin_cnt[k];
        r_sx[k]  <= w_fin_sx[k];
        r_sy[k]  <= w_fin_sy[k];
`ifdef CLUSTER_BBOX_EN
        r_xmin[k] <= w_fin_xmin[k];
        r_xmax[k] <= w_fin_xmax[k];
        r_ymin[k] <= w_fin_ymin[k];
        r_ymax[k] <= w_fin_ymax[k];
`endif
      end
    end
  end

  assign w_snap_go = r_s2_eof && r_state == S_IDLE;

  // Capture the finished frame for the divider.
  always_ff @(posedge clk) begin
    if (w_snap_go) begin
      for (int k = 0; k < NUM_CLUSTERS; k++) begin
        r_snap_cnt[k] <= w_fin_cnt[k];
        r_snap_sx[k]  <= w_fin_sx[k];
        r_snap_sy[k]  <= w_fin_sy[k];
`ifdef CLUSTER_BBOX_EN
        r_snap_xmin[k] <= w_fin_xmin[k];
        r_snap_xmax[k] <= w_fin_xmax[k];
        r_snap_ymin[k] <= w_fin_ymin[k];
        r_snap_ymax[k] <= w_fin_ymax[k];
`endif
      end
    end
  end

  // One restoring step; the first step of each quotient starts from the snapshot.
  always_comb begin
    w_cl       = IW'(r_sel >> 1);
    w_last_bit = r_bit == LAST_BIT;
    w_divisor  = r_snap_cnt[w_cl];
    if (r_bit == '0) begin
      w_dvd_in = r_sel[0] ? r_snap_sy[w_cl] : r_snap_sx[w_cl];
      w_rem_in = '0;
      w_quo_in = '0;
    end else begin
      w_dvd_in = r_dvd;
      w_rem_in = r_rem;
      w_quo_in = r_quo;
    end
    w_rem_sh = {w_rem_in, w_dvd_in[SUM_W-1]};
    w_ge     = w_rem_sh >= {1'b0, w_divisor};
    w_rem_nx = w_ge ? CW'(w_rem_sh - {1'b0, w_divisor}) : w_rem_sh[CW-1:0];
    w_quo_nx = (w_quo_in << 1) | QW'(w_ge);
  end

  // Divider datapath; an empty cluster keeps the same cycle budget but yields 0.
  always_ff @(posedge clk) begin
    if (r_state == S_DIV) begin
      r_dvd <= w_dvd_in << 1;
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
      if (w_last_bit) begin
        if (r_sel[0]) r_qy[w_cl] <= (w_divisor == '0) ? '0 : w_quo_nx[YW-1:0];
        else          r_qx[w_cl] <= (w_divisor == '0) ? '0 : w_quo_nx[XW-1:0];
      end
    end
  end

  // Frame FSM: IDLE -> DIV (x0,y0,x1,y1,...) -> LOAD, with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_sel        <= '0;
      r_bit        <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_found      <= '0;
      r_centroid_x <= '0;
      r_centroid_y <= '0;
`ifdef CLUSTER_BBOX_EN
      r_bbox_xmin  <= '0;
      r_bbox_xmax  <= '0;
      r_bbox_ymin  <= '0;
      r_bbox_ymax  <= '0;
`endif
    end else begin
      r_frame_done <= 1'b0;
      if (r_s2_eof && r_state != S_IDLE) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_snap_go) begin
            r_state <= S_DIV;
            r_sel   <= '0;
            r_bit   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_DIV: begin
          if (w_last_bit) begin
            r_bit <= '0;
            if (r_sel == LAST_SEL) r_state <= S_LOAD;
            else                   r_sel   <= r_sel + SW'(1);
          end else begin
            r_bit <= r_bit + BW'(1);
          end
        end
        S_LOAD: begin
          for (int k = 0; k < NUM_CLUSTERS; k++) begin
            r_found[k] <= r_snap_cnt[k] >= CW'(MIN_COUNT);
            if (r_snap_cnt[k] >= CW'(MIN_COUNT)) begin
              r_centroid_x[k*XW +: XW] <= r_qx[k];
              r_centroid_y[k*YW +: YW] <= r_qy[k];
`ifdef CLUSTER_BBOX_EN
              r_bbox_xmin[k*XW +: XW] <= r_snap_xmin[k];
              r_bbox_xmax[k*XW +: XW] <= r_snap_xmax[k];
              r_bbox_ymin[k*YW +: YW] <= r_snap_ymin[k];
              r_bbox_ymax[k*YW +: YW] <= r_snap_ymax[k];
`endif
            end
          end
          r_frame_done <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign centroid_x = r_centroid_x;
  assign centroid_y = r_centroid_y;
  assign found      = r_found;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;
  assign overrun    = r_overrun;
`ifdef CLUSTER_BBOX_EN
  assign bbox_xmin  = r_bbox_xmin;
  assign bbox_xmax  = r_bbox_xmax;
  assign bbox_ymin  = r_bbox_ymin;
  assign bbox_ymax  = r_bbox_ymax;
`endif

endmodule

// File: tb/tb_cluster_centroid_n.sv
// Testbench for cluster_centroid_n (default parameters, bbox feature off).
// Frames are sparse: only pixels of interest plus the frame-end coordinate
// are streamed. Stimulus pushes hand-computed results into a scoreboard; a
// monitor pops and compares on every frame_done, including its cycle.
module tb_cluster_centroid_n;

  localparam int XW  = 10;
  localparam int YW  = 9;
  localparam int N   = 3;
  localparam int LAT = 3 + 2 * N * 28;

  logic              clk = 1'b0;
  logic              rst;
  logic [11:0]       pixel_r, pixel_g, pixel_b;
  logic              pixel_valid;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic              ref_wr_en;
  logic [1:0]        ref_wr_idx;
  logic [11:0]       ref_wr_r, ref_wr_g, ref_wr_b;
  logic [N*XW-1:0]   centroid_x;
  logic [N*YW-1:0]   centroid_y;
  logic [N-1:0]      found;
  logic              frame_done, busy, overrun;

  cluster_centroid_n dut (
    .clk(clk), .rst(rst),
    .pixel_r(pixel_r), .pixel_g(pixel_g), .pixel_b(pixel_b),
    .pixel_valid(pixel_valid), .x(x), .y(y),
    .ref_wr_en(ref_wr_en), .ref_wr_idx(ref_wr_idx),
    .ref_wr_r(ref_wr_r), .ref_wr_g(ref_wr_g), .ref_wr_b(ref_wr_b),
    .centroid_x(centroid_x), .centroid_y(centroid_y), .found(found),
    .frame_done(frame_done), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N*XW-1:0] cx;
    logic [N*YW-1:0] cy;
    logic [N-1:0]    fd;
    longint          t;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pix(input int r, input int g, input int b, input int xx, input int yy);
    @(posedge clk); #1;
    pixel_r = 12'(r); pixel_g = 12'(g); pixel_b = 12'(b);
    x = XW'(xx); y = YW'(yy);
    pixel_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pixel_valid = 1'b0;
    end
  endtask

  // 4x4 block spanning c-2..c+1 in both axes.
  task automatic block4(input int r, input int g, input int b, input int cx, input int cy);
    for (int dy = -2; dy <= 1; dy++)
      for (int dx = -2; dx <= 1; dx++)
        pix(r, g, b, cx + dx, cy + dy);
  endtask

  // Frame-end pixel with its expected published result.
  task automatic frame_end(input int r, input int g, input int b,
                           input logic [N*XW-1:0] cx, input logic [N*YW-1:0] cy,
                           input logic [N-1:0] fd);
    exp_t e;
    pix(r, g, b, 639, 479);
    e.cx = cx; e.cy = cy; e.fd = fd;
    e.t  = cyc + 1 + LAT;
    sb.push_back(e);
  endtask

  task automatic wr_ref(input int idx, input int r, input int g, input int b);
    @(posedge clk); #1;
    pixel_valid = 1'b0;
    ref_wr_en = 1'b1; ref_wr_idx = 2'(idx);
    ref_wr_r = 12'(r); ref_wr_g = 12'(g); ref_wr_b = 12'(b);
    @(posedge clk); #1;
    ref_wr_en = 1'b0;
  endtask

  task automatic drain();
    int budget;
    idle(1);
    budget = 0;
    while (sb.size() != 0 && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout_pending", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic wait_idle();
    int budget;
    idle(1);
    budget = 0;
    while (busy !== 1'b0 && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    if (busy !== 1'b0) check("wait_idle_timeout", 64'(busy), 64'd0);
  endtask

  // Monitor: every frame_done must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_frame_done: got pulse at cycle %0d, expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("centroid_x", 64'(centroid_x), 64'(mon_e.cx));
        check("centroid_y", 64'(centroid_y), 64'(mon_e.cy));
        check("found",      64'(found),      64'(mon_e.fd));
        check("done_cycle", 64'(cyc),        64'(mon_e.t));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; pixel_valid = 1'b0; pixel_r = '0; pixel_g = '0; pixel_b = '0;
    x = '0; y = '0; ref_wr_en = 1'b0; ref_wr_idx = '0;
    ref_wr_r = '0; ref_wr_g = '0; ref_wr_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_centroid_x", 64'(centroid_x), 64'd0);
    check("rst_centroid_y", 64'(centroid_y), 64'd0);
    check("rst_found",      64'(found),      64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_busy",       64'(busy),       64'd0);
    check("rst_overrun",    64'(overrun),    64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Single cluster-0 block among background.
    pix(300, 300, 300, 0, 0);
    pix(300, 300, 300, 5, 5);
    block4(50, 100, 150, 160, 120);
    pix(300, 300, 300, 400, 300);
    frame_end(300, 300, 300, {10'd0, 10'd0, 10'd159}, {9'd0, 9'd0, 9'd119}, 3'b001);
    drain();

    // Three clusters, then a zero-gap second frame accumulated during the divide.
    block4(50, 100, 150, 160, 120);
    block4(500, 550, 600, 480, 120);
    block4(950, 1000, 1050, 320, 360);
    pix(300, 300, 300, 200, 200);
    frame_end(300, 300, 300, {10'd319, 10'd479, 10'd159}, {9'd359, 9'd119, 9'd119}, 3'b111);
    block4(50, 100, 150, 175, 120);
    @(negedge clk);
    check("busy_during_div", 64'(busy), 64'd1);
    wait_idle();
    frame_end(1500, 1500, 1500, {10'd319, 10'd479, 10'd174}, {9'd359, 9'd119, 9'd119}, 3'b001);
    drain();

    // Reference 1 rewritten mid-frame; two-pixel cluster 2 is not found and holds.
    block4(50, 100, 150, 160, 120);
    pix(950, 1000, 1050, 10, 20);
    pix(950, 1000, 1050, 12, 22);
    pix(300, 300, 300, 50, 50);
    wr_ref(1, 300, 300, 300);
    idle(1);
    pix(300, 300, 300, 100, 200);
    pix(300, 300, 300, 101, 200);
    pix(300, 300, 300, 102, 201);
    pix(300, 300, 300, 103, 201);
    frame_end(300, 300, 300, {10'd319, 10'd209, 10'd159}, {9'd359, 9'd256, 9'd119}, 3'b011);
    drain();

    // Frame end while the divider is busy: dropped, overrun sticks.
    block4(50, 100, 150, 160, 120);
    frame_end(1500, 1500, 1500, {10'd319, 10'd209, 10'd159}, {9'd359, 9'd256, 9'd119}, 3'b001);
    idle(5);
    @(negedge clk);
    check("busy_before_overrun", 64'(busy), 64'd1);
    check("overrun_not_yet",     64'(overrun), 64'd0);
    pix(950, 1000, 1050, 639, 479);
    drain();
    @(negedge clk);
    check("overrun_sticky", 64'(overrun), 64'd1);

    // Reset during the divide: no frame_done, everything back to zero.
    block4(50, 100, 150, 160, 120);
    pix(1500, 1500, 1500, 639, 479);
    idle(60);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_centroid_x", 64'(centroid_x), 64'd0);
    check("midrst_centroid_y", 64'(centroid_y), 64'd0);
    check("midrst_found",      64'(found),      64'd0);
    check("midrst_busy",       64'(busy),       64'd0);
    check("midrst_overrun",    64'(overrun),    64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(250);

    // Full frame after reset with default references restored.
    block4(50, 100, 150, 160, 120);
    block4(500, 550, 600, 480, 120);
    block4(950, 1000, 1050, 320, 360);
    frame_end(300, 300, 300, {10'd319, 10'd479, 10'd159}, {9'd359, 9'd119, 9'd119}, 3'b111);
    drain();
    idle(5);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
